ram_rd_stream: RTL and testbench

RAM_RD_STREAM -- requirements
Module: ram_rd_stream

---
 rtl/ram_rd_stream_if.sv | 27 ++
 rtl/ram_rd_stream.sv | 182 ++++++++++++++++++
 tb/tb_ram_rd_stream.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_rd_stream_if.sv
// Command and output-stream handshake bundle for the RAM read streamer.
// The streamer itself attaches through the slave modport.
interface ram_rd_stream_if #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 32
);
   logic             cmd_valid;
   logic             cmd_ready;
   logic [DEPTH-1:0] cmd_addr;
   logic [DEPTH:0]   cmd_len;

   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;
   logic             out_last;
   logic             out_perr;

   modport master (
      output cmd_valid, cmd_addr, cmd_len, out_ready,
      input  cmd_ready, out_valid, out_data, out_last, out_perr
   );

   modport slave (
      input  cmd_valid, cmd_addr, cmd_len, out_ready,
      output cmd_ready, out_valid, out_data, out_last, out_perr
   );
endinterface

// File: rtl/ram_rd_stream.sv
// Streams a contiguous (wrapping) range of RAM words to a ready/valid output,
// issuing reads only while the output buffer has room for every in-flight word.
module ram_rd_stream #(
   parameter int DEPTH      = 4,
   parameter int WIDTH      = 32,
   parameter int RD_LATENCY = 2,
   parameter int BUF_DEPTH  = 4
) (
   input  logic             clk,
   input  logic             rst,
   ram_rd_stream_if.slave   strm,
   output logic             ram_re,
   output logic [DEPTH-1:0] ram_raddr,
   input  logic [WIDTH-1:0] ram_dout,
   input  logic             ram_perr,
   output logic             busy,
   output logic             done,
   output logic             err_sticky
);

   localparam int PTR_W = $clog2(BUF_DEPTH);
   localparam int CNT_W = $clog2(BUF_DEPTH) + 2;
   localparam int ENT_W = WIDTH + 2;

   generate
      if (RD_LATENCY < 1 || RD_LATENCY > 3) begin : g_bad_latency
         $error("ram_rd_stream: RD_LATENCY must be 1..3");
      end
      if (((BUF_DEPTH & (BUF_DEPTH - 1)) != 0) || (BUF_DEPTH < RD_LATENCY + 1)) begin : g_bad_buf
         $error("ram_rd_stream: BUF_DEPTH must be a power of two and >= RD_LATENCY+1");
      end
   endgenerate

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   state_t                 state_q, state_d;
   logic [DEPTH-1:0]       next_addr_q, next_addr_d;
   logic [DEPTH-1:0]       last_addr_q, last_addr_d;
   logic [DEPTH:0]         rem_q, rem_d;
   logic [RD_LATENCY-1:0]  tag_vld_q, tag_vld_d;
   logic [RD_LATENCY-1:0]  tag_last_q, tag_last_d;
   logic [ENT_W-1:0]       mem_q [BUF_DEPTH];
   logic [ENT_W-1:0]       mem_d [BUF_DEPTH];
   logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]       count_q, count_d;
   logic                   done_q, done_d;
   logic                   err_q, err_d;

   logic [CNT_W-1:0]       inflight;
   logic [ENT_W-1:0]       head;
   logic                   accept;
   logic                   issue;
   logic                   buf_wr;
   logic                   pop;

   // Buffer entries are {data, perr, last}; a read may issue only when every
   // tag still in the pipeline plus every buffered word leaves a free slot.
   always_comb begin
      state_d     = state_q;
      next_addr_d = next_addr_q;
      last_addr_d = last_addr_q;
      rem_d       = rem_q;
      tag_vld_d   = '0;
      tag_last_d  = '0;
      mem_d       = mem_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      done_d      = 1'b0;
      err_d       = err_q;

      inflight = '0;
      for (int i = 0; i < RD_LATENCY; i++) begin
         inflight = inflight + CNT_W'(tag_vld_q[i]);
      end

      head   = mem_q[rd_ptr_q];
      accept = (state_q == IDLE) && strm.cmd_valid;
      issue  = (state_q == RUN) && (rem_q != '0) &&
               ((inflight + count_q) < CNT_W'(BUF_DEPTH));
      buf_wr = tag_vld_q[RD_LATENCY-1];
      pop    = (count_q != '0) && strm.out_ready;

      tag_vld_d[0]  = issue;
      tag_last_d[0] = issue && (rem_q == (DEPTH+1)'(1));
      for (int i = 1; i < RD_LATENCY; i++) begin
         tag_vld_d[i]  = tag_vld_q[i-1];
         tag_last_d[i] = tag_last_q[i-1];
      end

      if (buf_wr) begin
         mem_d[wr_ptr_q] = {ram_dout, ram_perr, tag_last_q[RD_LATENCY-1]};
         wr_ptr_d        = wr_ptr_q + 1'b1;
         if (ram_perr) begin
            err_d = 1'b1;
         end
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({buf_wr, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase

      if (issue) begin
         last_addr_d = next_addr_q;
         next_addr_d = next_addr_q + 1'b1;
         rem_d       = rem_q - 1'b1;
      end

      case (state_q)
         IDLE: begin
            if (accept) begin
               next_addr_d = strm.cmd_addr;
               rem_d       = strm.cmd_len;
               err_d       = 1'b0;
               if (strm.cmd_len == '0) begin
                  done_d = 1'b1;
               end else begin
                  state_d = RUN;
               end
            end
         end
         RUN: begin
            if (issue && (rem_q == (DEPTH+1)'(1))) begin
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (pop && head[0]) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         next_addr_q <= '0;
         last_addr_q <= '0;
         rem_q       <= '0;
         tag_vld_q   <= '0;
         tag_last_q  <= '0;
         mem_q       <= '{default: '0};
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         next_addr_q <= next_addr_d;
         last_addr_q <= last_addr_d;
         rem_q       <= rem_d;
         tag_vld_q   <= tag_vld_d;
         tag_last_q  <= tag_last_d;
         mem_q       <= mem_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         done_q      <= done_d;
         err_q       <= err_d;
      end
   end

   // The address output shows the last issued address whenever no read issues.
   assign ram_re          = issue;
   assign ram_raddr       = issue ? next_addr_q : last_addr_q;
   assign strm.cmd_ready  = (state_q == IDLE);
   assign strm.out_valid  = (count_q != '0);
   assign {strm.out_data, strm.out_perr, strm.out_last} = strm.out_valid ? head : '0;
   assign busy            = (state_q != IDLE);
   assign done            = done_q;
   assign err_sticky      = err_q;

endmodule

// File: tb/tb_ram_rd_stream.sv
// Scoreboard bench for ram_rd_stream: a RAM model with mem[i]=i+100 and a
// two-cycle read, expected addresses and beats queued as commands are driven.
module tb_ram_rd_stream;

   localparam int DEPTH      = 4;
   localparam int WIDTH      = 32;
   localparam int RD_LATENCY = 2;
   localparam int BUF_DEPTH  = 4;

   logic             clk = 1'b0;
   logic             rst;
   logic             ram_re;
   logic [DEPTH-1:0] ram_raddr;
   logic [WIDTH-1:0] ram_dout;
   logic             ram_perr;
   logic             busy;
   logic             done;
   logic             err_sticky;

   ram_rd_stream_if #(.DEPTH(DEPTH), .WIDTH(WIDTH)) bus ();

   ram_rd_stream #(
      .DEPTH(DEPTH), .WIDTH(WIDTH), .RD_LATENCY(RD_LATENCY), .BUF_DEPTH(BUF_DEPTH)
   ) dut (
      .clk(clk), .rst(rst), .strm(bus),
      .ram_re(ram_re), .ram_raddr(ram_raddr),
      .ram_dout(ram_dout), .ram_perr(ram_perr),
      .busy(busy), .done(done), .err_sticky(err_sticky)
   );

   always #5 clk = ~clk;

   int               vector_count = 0;
   int               miss_count   = 0;
   int               rd_count     = 0;
   int               perr_at      = -1;
   int               re_count     = 0;
   bit               mon_en       = 1'b0;
   bit               rand_ready   = 1'b0;
   bit               hold_ready   = 1'b1;
   logic [DEPTH-1:0] exp_addr [$];
   logic [WIDTH+1:0] exp_out  [$];
   logic [WIDTH-1:0] p1_data;
   logic             p1_perr;

   // RAM model: two register stages from read address to ram_dout, with a
   // parity error injected on one chosen absolute read index.
   always @(posedge clk) begin
      p1_data  <= 32'(ram_raddr) + 32'd100;
      p1_perr  <= (ram_re === 1'b1) && (rd_count == perr_at);
      if (ram_re === 1'b1) rd_count <= rd_count + 1;
      ram_dout <= p1_data;
      ram_perr <= p1_perr;
   end

   // Output-side ready: either held at a level chosen by the test or random.
   always @(posedge clk) begin
      #1;
      bus.out_ready = rand_ready ? 1'($urandom_range(0, 1)) : hold_ready;
   end

   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      vector_count++;
      if (observed !== expected) begin
         miss_count++;
         $display("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, observed, expected, $time);
      end
   endtask

   // Every issued read and every accepted beat is checked against the queues.
   always @(negedge clk) begin
      if (mon_en) begin
         if (ram_re === 1'b1) begin
            re_count++;
            if (exp_addr.size() > 0) checkOutput("raddr", 64'(ram_raddr), 64'(exp_addr.pop_front()));
            else checkOutput("ram_re_extra", 64'(ram_re), 64'd0);
         end
         if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            if (exp_out.size() > 0)
               checkOutput("out_beat", 64'({bus.out_data, bus.out_perr, bus.out_last}),
                           64'(exp_out.pop_front()));
            else checkOutput("out_extra", 64'(bus.out_valid), 64'd0);
         end
      end
   end

   task automatic checkResetState();
      checkOutput("rst_cmd_ready", 64'(bus.cmd_ready), 64'd1);
      checkOutput("rst_ram_re",    64'(ram_re),        64'd0);
      checkOutput("rst_raddr",     64'(ram_raddr),     64'd0);
      checkOutput("rst_out_valid", 64'(bus.out_valid), 64'd0);
      checkOutput("rst_out_data",  64'(bus.out_data),  64'd0);
      checkOutput("rst_out_last",  64'(bus.out_last),  64'd0);
      checkOutput("rst_out_perr",  64'(bus.out_perr),  64'd0);
      checkOutput("rst_busy",      64'(busy),          64'd0);
      checkOutput("rst_done",      64'(done),          64'd0);
      checkOutput("rst_err",       64'(err_sticky),    64'd0);
   endtask

   // Queues the expected reads/beats, then holds the command until accepted.
   task automatic applyStimulus(input int addr, input int len, input int perr_idx);
      bit acc;
      int a;
      for (int k = 0; k < len; k++) begin
         a = (addr + k) % 16;
         exp_addr.push_back(DEPTH'(a));
         exp_out.push_back({32'(a + 100), 1'(k == perr_idx), 1'(k == len - 1)});
      end
      perr_at = (perr_idx >= 0) ? rd_count + perr_idx : -1;
      @(posedge clk);
      #1;
      bus.cmd_valid = 1'b1;
      bus.cmd_addr  = DEPTH'(addr);
      bus.cmd_len   = (DEPTH+1)'(len);
      acc = 1'b0;
      for (int i = 0; i < 50 && !acc; i++) begin
         acc = bus.cmd_ready;
         @(posedge clk);
      end
      #1;
      bus.cmd_valid = 1'b0;
      if (!acc) checkOutput("cmd_accept_timeout", 64'd0, 64'd1);
   endtask

   task automatic waitDone(input int budget);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < budget && !seen; i++) begin
         @(negedge clk);
         seen = (done === 1'b1);
      end
      checkOutput("done_seen", 64'(seen), 64'd1);
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: observed no finish, expected finish before time limit");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int base;
      int addr;
      int len;
      int pidx;
      bit seen;

      rst           = 1'b1;
      bus.cmd_valid = 1'b0;
      bus.cmd_addr  = '0;
      bus.cmd_len   = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      mon_en = 1'b1;
      @(negedge clk);
      checkResetState();

      $display("[TB] basic stream addr=5 len=4 with cycle timing");
      applyStimulus(5, 4, -1);
      for (int off = 1; off <= 8; off++) begin
         @(negedge clk);
         checkOutput("t1_re", 64'(ram_re), 64'(off <= 4));
         if (off <= 4) checkOutput("t1_raddr", 64'(ram_raddr), 64'(4 + off));
         checkOutput("t1_valid", 64'(bus.out_valid), 64'(off >= 4 && off <= 7));
         if (off >= 4 && off <= 7) checkOutput("t1_data", 64'(bus.out_data), 64'(101 + off));
         checkOutput("t1_last", 64'(bus.out_last), 64'(off == 7));
         checkOutput("t1_done", 64'(done), 64'(off == 8));
      end
      checkOutput("t1_sb_left", 64'(exp_out.size()), 64'd0);

      $display("[TB] address wrap addr=14 len=4");
      applyStimulus(14, 4, -1);
      waitDone(100);
      checkOutput("wrap_sb_left", 64'(exp_out.size()), 64'd0);

      $display("[TB] parity error on second return");
      applyStimulus(3, 4, 1);
      waitDone(100);
      checkOutput("par_err_at_done", 64'(err_sticky), 64'd1);

      $display("[TB] zero-length command");
      applyStimulus(9, 0, -1);
      @(negedge clk);
      checkOutput("len0_done", 64'(done), 64'd1);
      checkOutput("len0_ready", 64'(bus.cmd_ready), 64'd1);
      checkOutput("len0_busy", 64'(busy), 64'd0);
      checkOutput("len0_err_cleared", 64'(err_sticky), 64'd0);
      @(negedge clk);
      checkOutput("len0_done_pulse", 64'(done), 64'd0);

      $display("[TB] backpressure len=16");
      hold_ready = 1'b0;
      @(negedge clk);
      base = re_count;
      applyStimulus(0, 16, -1);
      seen = 1'b0;
      for (int i = 0; i < 50 && !seen; i++) begin
         @(negedge clk);
         seen = (bus.out_valid === 1'b1);
      end
      checkOutput("bp_first_valid", 64'(seen), 64'd1);
      for (int i = 0; i < 10; i++) begin
         if (i == 3) begin
            bus.cmd_valid = 1'b1;
            bus.cmd_addr  = 4'd9;
            bus.cmd_len   = 5'd3;
         end
         if (i == 5) bus.cmd_valid = 1'b0;
         @(negedge clk);
         checkOutput("bp_hold_valid", 64'(bus.out_valid), 64'd1);
         checkOutput("bp_hold_data", 64'(bus.out_data), 64'd100);
         if (i == 4) checkOutput("busy_reject", 64'(bus.cmd_ready), 64'd0);
      end
      checkOutput("bp_reads_capped", 64'(re_count - base), 64'(BUF_DEPTH));
      hold_ready = 1'b1;
      waitDone(200);
      checkOutput("bp_sb_left", 64'(exp_out.size()), 64'd0);

      $display("[TB] reset after three reads of eight");
      applyStimulus(0, 8, -1);
      repeat (3) begin
         @(posedge clk);
         #1;
      end
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      exp_addr.delete();
      exp_out.delete();
      @(negedge clk);
      checkResetState();
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         checkOutput("post_rst_valid", 64'(bus.out_valid), 64'd0);
      end
      applyStimulus(0, 2, -1);
      waitDone(100);
      checkOutput("post_rst_sb_left", 64'(exp_out.size()), 64'd0);

      $display("[TB] random commands with random out_ready");
      rand_ready = 1'b1;
      for (int n = 0; n < 4; n++) begin
         addr = int'($urandom_range(0, 15));
         len  = int'($urandom_range(1, 16));
         if ($urandom_range(0, 1) == 1) pidx = int'($urandom_range(0, len - 1));
         else pidx = -1;
         applyStimulus(addr, len, pidx);
         waitDone(400);
         checkOutput("rnd_err", 64'(err_sticky), 64'(pidx >= 0));
         checkOutput("rnd_sb_left", 64'(exp_out.size()), 64'd0);
      end
      rand_ready = 1'b0;
      repeat (3) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", vector_count, miss_count);
      $finish;
   end

endmodule
